// File: rtl/board_engine.sv
// Sliding-tile board engine: one line per cycle move processing, LFSR tile spawn,
// and game-over/win evaluation over a registered N x N exponent grid.
module board_engine #(
    parameter int unsigned N       = 4,
    parameter int unsigned EW      = 4,
    parameter int unsigned WIN_EXP = 11,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              move_valid,
    input  logic [1:0]        move_dir,
    output logic              move_ready,
    input  logic              load_valid,
    input  logic [N*N*EW-1:0] load_board,
    output logic [N*N*EW-1:0] board_out,
    output logic [31:0]       score,
    output logic              move_done,
    output logic              moved,
    output logic              game_over,
    output logic              win
);

    localparam int unsigned CELLS = N * N;
    localparam int unsigned BW    = CELLS * EW;
    localparam int unsigned LBW   = N * EW;
    localparam int unsigned CW    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int unsigned LW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [EW-1:0] EMAX      = '1;
    localparam logic [15:0]   LFSR_TAPS = 16'hB400;
    localparam logic [BW-1:0] RESET_BOARD =
        BW'(1) << (32'(SEED % 16'(CELLS)) * EW);

    typedef enum logic [1:0] {
        IDLE,
        LINE,
        SPAWN,
        CHECK
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   board_q, board_d;
    logic [31:0]     score_q, score_d;
    logic [1:0]      dir_q, dir_d;
    logic [LW-1:0]   line_q, line_d;
    logic            changed_q, changed_d;
    logic [CW-1:0]   spawn_q, spawn_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic            done_q, done_d;
    logic            moved_q, moved_d;
    logic            over_q, over_d;
    logic            win_q, win_d;
    logic            ready_q, ready_d;

    logic [LBW-1:0]  line_in;
    logic [LBW-1:0]  line_mrg;
    logic [LBW-1:0]  line_out;
    logic [32:0]     line_acc;
    logic [EW-1:0]   mrg_e;

    // Board cell index of position pos (0 = move edge) within line ln for a direction.
    function automatic int unsigned cell_index(input logic [1:0] dir,
                                               input int unsigned ln,
                                               input int unsigned pos);
        case (dir)
            2'b00:   return ln * N + pos;
            2'b01:   return ln * N + (N - 1 - pos);
            2'b10:   return pos * N + ln;
            default: return (N - 1 - pos) * N + ln;
        endcase
    endfunction

    function automatic logic [LBW-1:0] compact(input logic [LBW-1:0] v);
        logic [LBW-1:0] r;
        int unsigned    wr;
        r  = '0;
        wr = 0;
        for (int unsigned p = 0; p < N; p++) begin
            if (v[p*EW +: EW] != '0) begin
                r[wr*EW +: EW] = v[p*EW +: EW];
                wr++;
            end
        end
        return r;
    endfunction

    // Adds 2^g to a score held in the low 32 bits, clamping at all-ones.
    function automatic logic [32:0] sat_add(input logic [32:0] acc, input logic [EW-1:0] g);
        logic [32:0] sum;
        if (32'(g) >= 32) begin
            return {1'b0, 32'hFFFF_FFFF};
        end
        sum = acc + (33'd1 << g);
        if (sum[32]) begin
            return {1'b0, 32'hFFFF_FFFF};
        end
        return sum;
    endfunction

    function automatic logic board_stuck(input logic [BW-1:0] b);
        logic        stuck;
        logic [EW-1:0] e;
        stuck = 1'b1;
        for (int unsigned r = 0; r < N; r++) begin
            for (int unsigned c = 0; c < N; c++) begin
                e = b[(r*N+c)*EW +: EW];
                if (e == '0) begin
                    stuck = 1'b0;
                end
                if (c < N - 1 && e != EMAX && e == b[(r*N+c+1)*EW +: EW]) begin
                    stuck = 1'b0;
                end
                if (r < N - 1 && e != EMAX && e == b[((r+1)*N+c)*EW +: EW]) begin
                    stuck = 1'b0;
                end
            end
        end
        return stuck;
    endfunction

    function automatic logic board_win(input logic [BW-1:0] b);
        logic hit;
        hit = 1'b0;
        for (int unsigned k = 0; k < CELLS; k++) begin
            if (32'(b[k*EW +: EW]) >= WIN_EXP) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Gather the active line, ordered from the move edge outward.
    always_comb begin
        line_in = '0;
        for (int unsigned p = 0; p < N; p++) begin
            line_in[p*EW +: EW] = board_q[cell_index(dir_q, 32'(line_q), p)*EW +: EW];
        end
    end

    // Compact, single-pass merge from the edge (merged cell zeroes its partner), compact.
    always_comb begin
        line_mrg = compact(line_in);
        line_acc = {1'b0, score_q};
        mrg_e    = '0;
        for (int unsigned p = 0; p + 1 < N; p++) begin
            mrg_e = line_mrg[p*EW +: EW];
            if (mrg_e != '0 && mrg_e != EMAX && mrg_e == line_mrg[(p+1)*EW +: EW]) begin
                line_mrg[p*EW +: EW]     = mrg_e + EW'(1);
                line_mrg[(p+1)*EW +: EW] = '0;
                line_acc                 = sat_add(line_acc, mrg_e + EW'(1));
            end
        end
        line_out = compact(line_mrg);
    end

    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        score_d   = score_q;
        dir_d     = dir_q;
        line_d    = line_q;
        changed_d = changed_q;
        spawn_d   = spawn_q;
        lfsr_d    = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
        done_d    = 1'b0;
        moved_d   = 1'b0;
        over_d    = over_q;
        win_d     = win_q;

        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    board_d = load_board;
                    score_d = '0;
                    win_d   = 1'b0;
                    over_d  = board_stuck(load_board);
                end else if (move_valid) begin
                    dir_d     = move_dir;
                    line_d    = '0;
                    changed_d = 1'b0;
                    state_d   = LINE;
                end
            end
            LINE: begin
                for (int unsigned p = 0; p < N; p++) begin
                    board_d[cell_index(dir_q, 32'(line_q), p)*EW +: EW] = line_out[p*EW +: EW];
                end
                score_d   = line_acc[31:0];
                changed_d = changed_q | (line_out != line_in);
                if (line_q == LW'(N - 1)) begin
                    if (changed_d) begin
                        state_d = SPAWN;
                        spawn_d = CW'(lfsr_q % 16'(CELLS));
                    end else begin
                        state_d = CHECK;
                    end
                end else begin
                    line_d = line_q + LW'(1);
                end
            end
            SPAWN: begin
                // A changed board always has an empty cell, so this scan terminates.
                if (board_q[32'(spawn_q)*EW +: EW] == '0) begin
                    board_d[32'(spawn_q)*EW +: EW] = (lfsr_q[3:0] == 4'd0) ? EW'(2) : EW'(1);
                    state_d = CHECK;
                end else if (spawn_q == CW'(CELLS - 1)) begin
                    spawn_d = '0;
                end else begin
                    spawn_d = spawn_q + CW'(1);
                end
            end
            CHECK: begin
                over_d  = board_stuck(board_q);
                win_d   = win_q | board_win(board_q);
                done_d  = 1'b1;
                moved_d = changed_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            board_q   <= RESET_BOARD;
            score_q   <= '0;
            dir_q     <= '0;
            line_q    <= '0;
            changed_q <= 1'b0;
            spawn_q   <= '0;
            lfsr_q    <= SEED;
            done_q    <= 1'b0;
            moved_q   <= 1'b0;
            over_q    <= 1'b0;
            win_q     <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            score_q   <= score_d;
            dir_q     <= dir_d;
            line_q    <= line_d;
            changed_q <= changed_d;
            spawn_q   <= spawn_d;
            lfsr_q    <= lfsr_d;
            done_q    <= done_d;
            moved_q   <= moved_d;
            over_q    <= over_d;
            win_q     <= win_d;
            ready_q   <= ready_d;
        end
    end

    assign move_ready = ready_q;
    assign board_out  = board_q;
    assign score      = score_q;
    assign move_done  = done_q;
    assign moved      = moved_q;
    assign game_over  = over_q;
    assign win        = win_q;

endmodule

// File: tb/tb_board_engine.sv
// Directed bench for board_engine at N=4, EW=4: merges, directions, no-op moves,
// game over, max-tile behaviour, ignored requests and reset during a move.
`timescale 1ns/1ps
module tb_board_engine;

    localparam int unsigned BW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          move_valid;
    logic [1:0]    move_dir;
    logic          move_ready;
    logic          load_valid;
    logic [BW-1:0] load_board;
    logic [BW-1:0] board_out;
    logic [31:0]   score;
    logic          move_done;
    logic          moved;
    logic          game_over;
    logic          win;

    int total = 0;
    int bad   = 0;

    board_engine #(.N(4), .EW(4), .WIN_EXP(11), .SEED(16'hACE1)) dut (
        .clk        (clk),
        .rst        (rst),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .move_ready (move_ready),
        .load_valid (load_valid),
        .load_board (load_board),
        .board_out  (board_out),
        .score      (score),
        .move_done  (move_done),
        .moved      (moved),
        .game_over  (game_over),
        .win        (win)
    );

    always #5 clk = ~clk;

    // Each row argument reads left to right as columns 0..3, one hex digit per cell.
    function automatic logic [63:0] rows(input logic [15:0] r0, input logic [15:0] r1,
                                         input logic [15:0] r2, input logic [15:0] r3);
        logic [63:0] lanes;
        logic [63:0] b;
        lanes = {r3, r2, r1, r0};
        b = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                b[(r*4+c)*4 +: 4] = lanes[r*16 + (3-c)*4 +: 4];
            end
        end
        return b;
    endfunction

    // Cells that differ from the expected board other than by a fresh 1/2 tile in an empty cell.
    function automatic void spawn_diff(input logic [63:0] act, input logic [63:0] exp,
                                       output int stray, output int spawned);
        logic [3:0] a;
        logic [3:0] e;
        stray   = 0;
        spawned = 0;
        for (int k = 0; k < 16; k++) begin
            a = act[k*4 +: 4];
            e = exp[k*4 +: 4];
            if (a != e) begin
                if (e == 4'd0 && (a == 4'd1 || a == 4'd2)) spawned++;
                else stray++;
            end
        end
    endfunction

    task automatic load(input logic [63:0] b);
        @(posedge clk); #1;
        load_valid = 1'b1;
        load_board = b;
        @(posedge clk); #1;
        load_valid = 1'b0;
    endtask

    // Returns cycles from the acceptance edge to the move_done sample, or -1 on timeout.
    task automatic do_move(input logic [1:0] d, output int lat);
        @(posedge clk); #1;
        move_valid = 1'b1;
        move_dir   = d;
        @(posedge clk); #1;
        move_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (move_done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; move_valid = 1'b0; load_valid = 1'b0; move_dir = 2'b00; load_board = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        total++; if (board_out !== 64'h10) begin bad++; $display("FAIL reset_board got %h want %h", board_out, 64'h10); end
        total++; if (score !== 32'd0) begin bad++; $display("FAIL reset_score got %0d want 0", score); end
        total++; if (move_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", move_ready); end
        total++; if (game_over !== 1'b0 || win !== 1'b0) begin bad++; $display("FAIL reset_flags got over=%b win=%b want 0 0", game_over, win); end
        total++; if (move_done !== 1'b0 || moved !== 1'b0) begin bad++; $display("FAIL reset_pulses got done=%b moved=%b want 0 0", move_done, moved); end
    endtask

    task automatic test_merge_left();
        int lat, stray, spawned;
        logic [63:0] exp;
        load(rows(16'h1111, 16'h3456, 16'h4365, 16'h3450));
        do_move(2'b00, lat);
        exp = rows(16'h2200, 16'h3456, 16'h4365, 16'h3450);
        spawn_diff(board_out, exp, stray, spawned);
        total++; if (lat < 6 || lat > 21) begin bad++; $display("FAIL merge_left_latency got %0d want 6..21", lat); end
        total++; if (moved !== 1'b1) begin bad++; $display("FAIL merge_left_moved got %b want 1", moved); end
        total++; if (score !== 32'd8) begin bad++; $display("FAIL merge_left_score got %0d want 8", score); end
        total++; if (stray !== 0 || spawned !== 1) begin bad++; $display("FAIL merge_left_board got %h stray=%0d spawned=%0d want base %h plus one tile", board_out, stray, spawned, exp); end
        total++; if (game_over !== 1'b0 || win !== 1'b0) begin bad++; $display("FAIL merge_left_flags got over=%b win=%b want 0 0", game_over, win); end
    endtask

    task automatic test_no_chain();
        int lat, stray, spawned;
        logic [63:0] exp;
        load(rows(16'h1120, 16'h0000, 16'h0000, 16'h0000));
        do_move(2'b00, lat);
        exp = rows(16'h2200, 16'h0000, 16'h0000, 16'h0000);
        spawn_diff(board_out, exp, stray, spawned);
        total++; if (score !== 32'd4) begin bad++; $display("FAIL no_chain_score got %0d want 4", score); end
        total++; if (stray !== 0 || spawned !== 1) begin bad++; $display("FAIL no_chain_board got %h stray=%0d spawned=%0d want base %h plus one tile", board_out, stray, spawned, exp); end
        total++; if (moved !== 1'b1) begin bad++; $display("FAIL no_chain_moved got %b want 1", moved); end
    endtask

    task automatic test_directions();
        int lat, stray, spawned;
        logic [63:0] exp;
        load(rows(16'h1102, 16'h0000, 16'h0000, 16'h0000));
        do_move(2'b01, lat);
        exp = rows(16'h0022, 16'h0000, 16'h0000, 16'h0000);
        spawn_diff(board_out, exp, stray, spawned);
        total++; if (score !== 32'd4) begin bad++; $display("FAIL right_score got %0d want 4", score); end
        total++; if (stray !== 0 || spawned !== 1) begin bad++; $display("FAIL right_board got %h want base %h plus one tile", board_out, exp); end

        load(rows(16'h0000, 16'h3000, 16'h3000, 16'h3000));
        do_move(2'b10, lat);
        exp = rows(16'h4000, 16'h3000, 16'h0000, 16'h0000);
        spawn_diff(board_out, exp, stray, spawned);
        total++; if (score !== 32'd16) begin bad++; $display("FAIL up_score got %0d want 16", score); end
        total++; if (stray !== 0 || spawned !== 1) begin bad++; $display("FAIL up_board got %h want base %h plus one tile", board_out, exp); end

        load(rows(16'h0200, 16'h0200, 16'h0200, 16'h0200));
        do_move(2'b11, lat);
        exp = rows(16'h0000, 16'h0000, 16'h0300, 16'h0300);
        spawn_diff(board_out, exp, stray, spawned);
        total++; if (score !== 32'd16) begin bad++; $display("FAIL down_score got %0d want 16", score); end
        total++; if (stray !== 0 || spawned !== 1) begin bad++; $display("FAIL down_board got %h want base %h plus one tile", board_out, exp); end
    endtask

    task automatic test_game_over();
        int lat;
        logic [63:0] b;
        b = rows(16'h1234, 16'h5678, 16'h1234, 16'h5678);
        load(b);
        total++; if (game_over !== 1'b1) begin bad++; $display("FAIL over_after_load got %b want 1", game_over); end
        do_move(2'b00, lat);
        total++; if (lat !== 5) begin bad++; $display("FAIL over_latency got %0d want 5", lat); end
        total++; if (moved !== 1'b0) begin bad++; $display("FAIL over_moved got %b want 0", moved); end
        total++; if (board_out !== b) begin bad++; $display("FAIL over_board got %h want %h", board_out, b); end
        total++; if (game_over !== 1'b1 || score !== 32'd0) begin bad++; $display("FAIL over_state got over=%b score=%0d want 1 0", game_over, score); end
    endtask

    task automatic test_max_tile();
        int lat;
        logic [63:0] b;
        b = rows(16'hFF00, 16'h0000, 16'h0000, 16'h0000);
        load(b);
        total++; if (game_over !== 1'b0) begin bad++; $display("FAIL max_over_load got %b want 0", game_over); end
        do_move(2'b00, lat);
        total++; if (lat !== 5) begin bad++; $display("FAIL max_latency got %0d want 5", lat); end
        total++; if (moved !== 1'b0 || board_out !== b) begin bad++; $display("FAIL max_board got moved=%b board=%h want 0 %h", moved, board_out, b); end
        total++; if (score !== 32'd0) begin bad++; $display("FAIL max_score got %0d want 0", score); end
        total++; if (win !== 1'b1) begin bad++; $display("FAIL max_win got %b want 1", win); end
    endtask

    task automatic test_ignore_during_move();
        int dones;
        logic [63:0] b;
        b = rows(16'h1234, 16'h5678, 16'h1234, 16'h5678);
        load(b);
        total++; if (win !== 1'b0) begin bad++; $display("FAIL load_clears_win got %b want 0", win); end
        @(posedge clk); #1;
        move_valid = 1'b1; move_dir = 2'b00;
        @(posedge clk); #1;
        move_valid = 1'b0;
        @(posedge clk); #1;
        move_valid = 1'b1; move_dir = 2'b01;
        @(posedge clk); #1;
        move_valid = 1'b0;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            if (move_done) dones++;
            @(posedge clk); #1;
        end
        total++; if (dones !== 1) begin bad++; $display("FAIL ignore_done_count got %0d want 1", dones); end
        total++; if (move_ready !== 1'b1 || board_out !== b) begin bad++; $display("FAIL ignore_final got ready=%b board=%h want 1 %h", move_ready, board_out, b); end
    endtask

    task automatic test_reset_mid_line();
        load(rows(16'h1100, 16'h0000, 16'h0000, 16'h0000));
        @(posedge clk); #1;
        move_valid = 1'b1; move_dir = 2'b00;
        @(posedge clk); #1;
        move_valid = 1'b0;
        total++; if (move_ready !== 1'b0) begin bad++; $display("FAIL busy_ready got %b want 0", move_ready); end
        @(posedge clk); #1;
        total++; if (board_out !== rows(16'h2000, 16'h0000, 16'h0000, 16'h0000) || score !== 32'd4) begin
            bad++; $display("FAIL line0_partial got board=%h score=%0d want %h 4", board_out, score, rows(16'h2000, 16'h0000, 16'h0000, 16'h0000));
        end
        move_valid = 1'b1; move_dir = 2'b01;
        @(posedge clk); #1;
        move_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (board_out !== 64'h10 || score !== 32'd0) begin bad++; $display("FAIL abort_board got board=%h score=%0d want %h 0", board_out, score, 64'h10); end
        total++; if (move_ready !== 1'b1 || move_done !== 1'b0 || moved !== 1'b0 || game_over !== 1'b0 || win !== 1'b0) begin
            bad++; $display("FAIL abort_flags got ready=%b done=%b moved=%b over=%b win=%b want 1 0 0 0 0", move_ready, move_done, moved, game_over, win);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (board_out !== 64'h10 || move_ready !== 1'b1) begin bad++; $display("FAIL after_abort got board=%h ready=%b want %h 1", board_out, move_ready, 64'h10); end
    endtask

    initial begin
        test_reset();
        test_merge_left();
        test_no_chain();
        test_directions();
        test_game_over();
        test_max_tile();
        test_ignore_during_move();
        test_reset_mid_line();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
